// File: rtl/test_i_if.sv
// Handshake bundle for the two-stage test_i transfer pipeline.
// The c_par signal exists only when TEST_I_PARITY_EN is defined.
interface test_i_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b;
    logic             b_valid;
    logic [WIDTH-1:0] c;
    logic             c_valid;
    logic             c_ready;
    logic             d;
    logic [CNT_W-1:0] cnt;
`ifdef TEST_I_PARITY_EN
    logic             c_par;
`endif

    // Source/sink side: drives the input word and the output acceptance.
    modport master (
        output a, a_valid, c_ready,
        input  a_ready, b, b_valid, c, c_valid, d, cnt
`ifdef TEST_I_PARITY_EN
        , input c_par
`endif
    );

    // Pipeline side.
    modport slave (
        input  a, a_valid, c_ready,
        output a_ready, b, b_valid, c, c_valid, d, cnt
`ifdef TEST_I_PARITY_EN
        , output c_par
`endif
    );
endinterface

// File: rtl/test_i.sv
// Two-stage registered valid/ready pipeline (a -> b -> c) with alive flag and delivered-word count.
// Optional feature macro TEST_I_PARITY_EN adds a registered even-parity bit c_par alongside c.
module test_i #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 16
) (
    input logic   clk,
    input logic   rst,
    test_i_if.slave bus
);
    logic [WIDTH-1:0] b_q, b_d;
    logic             b_valid_q, b_valid_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             c_valid_q, c_valid_d;
    logic             d_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s2_take;
    logic a_ready;
    logic in_xfer;
    logic handoff;
    logic out_xfer;

    // Readies depend only on registered valids and c_ready, never on a_valid.
    assign s2_take  = !c_valid_q || bus.c_ready;
    assign a_ready  = !b_valid_q || s2_take;
    assign in_xfer  = bus.a_valid && a_ready;
    assign handoff  = b_valid_q && s2_take;
    assign out_xfer = c_valid_q && bus.c_ready;

    always_comb begin
        b_d       = b_q;
        b_valid_d = b_valid_q;
        c_d       = c_q;
        c_valid_d = c_valid_q;
        cnt_d     = cnt_q;

        if (out_xfer) begin
            c_valid_d = 1'b0;
            cnt_d     = cnt_q + CNT_W'(1);
        end
        if (handoff) begin
            c_d       = b_q;
            c_valid_d = 1'b1;
            b_valid_d = 1'b0;
        end
        if (in_xfer) begin
            b_d       = bus.a;
            b_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q       <= '0;
            b_valid_q <= 1'b0;
            c_q       <= '0;
            c_valid_q <= 1'b0;
            d_q       <= 1'b0;
            cnt_q     <= '0;
        end else begin
            b_q       <= b_d;
            b_valid_q <= b_valid_d;
            c_q       <= c_d;
            c_valid_q <= c_valid_d;
            d_q       <= 1'b1;
            cnt_q     <= cnt_d;
        end
    end

`ifdef TEST_I_PARITY_EN
    logic c_par_q, c_par_d;

    always_comb begin
        c_par_d = c_par_q;
        if (handoff) begin
            c_par_d = ^b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_par_q <= 1'b0;
        end else begin
            c_par_q <= c_par_d;
        end
    end

    assign bus.c_par = c_par_q;
`endif

    assign bus.a_ready = a_ready;
    assign bus.b       = b_q;
    assign bus.b_valid = b_valid_q;
    assign bus.c       = c_q;
    assign bus.c_valid = c_valid_q;
    assign bus.d       = d_q;
    assign bus.cnt     = cnt_q;
endmodule

// File: tb/tb_test_i.sv
// Self-checking bench for test_i: scoreboard queue of accepted words checked at the output.
// Parity checks are active when TEST_I_PARITY_EN is defined.
module tb_test_i;
    localparam int unsigned WIDTH = 5;
    localparam int unsigned CNT_W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [WIDTH-1:0] sb_q[$];

    test_i_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    test_i #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so at negedge they show what the next edge will do.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.c_valid && bus.c_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_order: c=%h delivered but none expected", bus.c);
                end else begin
                    if (bus.c !== sb_q[0]) begin
                        errors++;
                        $display("FAIL sb_order: c=%h expected %h", bus.c, sb_q[0]);
                    end
                    void'(sb_q.pop_front());
                end
            end
            if (bus.a_valid && bus.a_ready) begin
                sb_q.push_back(bus.a);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.a       = 5'h1f;
        bus.a_valid = 1'b1;
        bus.c_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.b !== 5'd0 || bus.b_valid !== 1'b0 || bus.c !== 5'd0 || bus.c_valid !== 1'b0
            || bus.d !== 1'b0 || bus.cnt !== 16'd0 || bus.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_vals: b=%h bv=%b c=%h cv=%b d=%b cnt=%0d ar=%b want all 0, ar=1",
                     bus.b, bus.b_valid, bus.c, bus.c_valid, bus.d, bus.cnt, bus.a_ready);
        end
`ifdef TEST_I_PARITY_EN
        checks++;
        if (bus.c_par !== 1'b0) begin
            errors++;
            $display("FAIL reset_par: c_par=%b expected 0", bus.c_par);
        end
`endif
        rst         = 1'b0;
        bus.a_valid = 1'b0;
        tick();
        checks++;
        if (bus.d !== 1'b1) begin
            errors++;
            $display("FAIL alive_flag: d=%b expected 1", bus.d);
        end
    endtask

    task automatic test_single();
        bus.a       = 5'b10110;
        bus.a_valid = 1'b1;
        bus.c_ready = 1'b1;
        tick();
        bus.a_valid = 1'b0;
        checks++;
        if (bus.b !== 5'b10110 || bus.b_valid !== 1'b1 || bus.c_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_b: b=%b bv=%b cv=%b expected 10110 1 0",
                     bus.b, bus.b_valid, bus.c_valid);
        end
        tick();
        checks++;
        if (bus.c !== 5'b10110 || bus.c_valid !== 1'b1 || bus.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_c: c=%b cv=%b bv=%b expected 10110 1 0",
                     bus.c, bus.c_valid, bus.b_valid);
        end
`ifdef TEST_I_PARITY_EN
        checks++;
        if (bus.c_par !== 1'b1) begin
            errors++;
            $display("FAIL parity_one: c_par=%b expected 1", bus.c_par);
        end
`endif
        tick();
        checks++;
        if (bus.cnt !== 16'd1 || bus.c_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt: cnt=%0d cv=%b expected 1 0", bus.cnt, bus.c_valid);
        end
    endtask

    task automatic test_stream();
        bus.c_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.a       = WIDTH'(i);
            bus.a_valid = 1'b1;
            checks++;
            if (bus.a_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready: word %0d a_ready=%b expected 1", i, bus.a_ready);
            end
            tick();
            if (i > 1) begin
                checks++;
                if (bus.c !== WIDTH'(i - 1) || bus.c_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_c: c=%0d cv=%b expected %0d 1",
                             bus.c, bus.c_valid, i - 1);
                end
            end
        end
        bus.a_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus.cnt !== 16'd9 || bus.c_valid !== 1'b0 || bus.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_cnt: cnt=%0d cv=%b bv=%b expected 9 0 0",
                     bus.cnt, bus.c_valid, bus.b_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.c_ready = 1'b0;
        bus.a       = 5'd1;
        bus.a_valid = 1'b1;
        tick();
        bus.a = 5'd2;
        tick();
        bus.a = 5'd3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.a_ready !== 1'b0 || bus.b !== 5'd2 || bus.c !== 5'd1
                || bus.b_valid !== 1'b1 || bus.c_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: ar=%b b=%0d c=%0d bv=%b cv=%b expected 0 2 1 1 1",
                         bus.a_ready, bus.b, bus.c, bus.b_valid, bus.c_valid);
            end
            tick();
        end
        bus.c_ready = 1'b1;
        tick();
        bus.a_valid = 1'b0;
        checks++;
        if (bus.c !== 5'd2 || bus.b !== 5'd3) begin
            errors++;
            $display("FAIL bp_release: c=%0d b=%0d expected 2 3", bus.c, bus.b);
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus.cnt !== 16'd12 || sb_q.size() != 0 || bus.c_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: cnt=%0d pending=%0d cv=%b expected 12 0 0",
                     bus.cnt, sb_q.size(), bus.c_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.c_ready = 1'b0;
        bus.a       = 5'd4;
        bus.a_valid = 1'b1;
        tick();
        bus.a = 5'd5;
        tick();
        bus.a_valid = 1'b0;
        rst         = 1'b1;
        tick();
        checks++;
        if (bus.b_valid !== 1'b0 || bus.c_valid !== 1'b0 || bus.cnt !== 16'd0
            || bus.d !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: bv=%b cv=%b cnt=%0d d=%b expected 0 0 0 0",
                     bus.b_valid, bus.c_valid, bus.cnt, bus.d);
        end
        rst         = 1'b0;
        bus.c_ready = 1'b1;
        bus.a       = 5'd7;
        bus.a_valid = 1'b1;
        tick();
        bus.a = 5'd0;
        checks++;
        if (bus.b !== 5'd7 || bus.b_valid !== 1'b1 || bus.c_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_lat_b: b=%0d bv=%b cv=%b expected 7 1 0",
                     bus.b, bus.b_valid, bus.c_valid);
        end
        tick();
        bus.a_valid = 1'b0;
        checks++;
        if (bus.c !== 5'd7 || bus.c_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_lat_c: c=%0d cv=%b expected 7 1", bus.c, bus.c_valid);
        end
        tick();
        checks++;
        if (bus.c !== 5'd0 || bus.c_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_word: c=%0d cv=%b expected 0 1", bus.c, bus.c_valid);
        end
`ifdef TEST_I_PARITY_EN
        checks++;
        if (bus.c_par !== 1'b0) begin
            errors++;
            $display("FAIL parity_zero: c_par=%b expected 0", bus.c_par);
        end
`endif
        tick();
        tick();
        checks++;
        if (bus.cnt !== 16'd2 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL mid_drain: cnt=%0d pending=%0d expected 2 0", bus.cnt, sb_q.size());
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.a       = '0;
        bus.a_valid = 1'b0;
        bus.c_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
